// File: rtl/fp_operand_seq_if.sv
// Operand-load bus between the integer write path and the FPU operand sequencer.
// Carries load control, the word handshake, and the mantissa-decoder control set.
interface fp_operand_seq_if #(
  parameter int DATA_W = 32
);
  logic              ld_start;
  logic [1:0]        ld_fmt;
  logic              ld_two;
  logic              flush;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [DATA_W-1:0] op_hi;
  logic [DATA_W-1:0] op_lo;
  logic              cyc0_rdy;
  logic              cyc1_rdy;
  logic [2:0]        cyc0_type;
  logic              busy;
  logic              op_done;

  modport master (
    output ld_start, ld_fmt, ld_two, flush,
    output in_valid, in_data,
    input  in_ready, op_hi, op_lo,
    input  cyc0_rdy, cyc1_rdy, cyc0_type,
    input  busy, op_done
  );

  modport slave (
    input  ld_start, ld_fmt, ld_two, flush,
    input  in_valid, in_data,
    output in_ready, op_hi, op_lo,
    output cyc0_rdy, cyc1_rdy, cyc0_type,
    output busy, op_done
  );
endinterface

// File: rtl/fp_operand_seq.sv
// Operand-load sequencer feeding the FPU mantissa decoder.
// Assembles 32-bit words into a 64-bit hold register and pulses cyc0/cyc1 ready.
module fp_operand_seq #(
  parameter int DATA_W = 32
) (
  input logic             clk,
  input logic             reset,
  fp_operand_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_L0_HI,
    S_L0_LO,
    S_CYC0,
    S_L1_HI,
    S_L1_LO,
    S_CYC1
  } state_t;

  state_t            r_state;
  state_t            w_nxt;
  logic              r_wide;
  logic              r_two;
  logic [2:0]        r_type;
  logic [DATA_W-1:0] r_op_hi;
  logic [DATA_W-1:0] r_op_lo;
  logic              r_in_ready;
  logic              r_busy;
  logic              r_cyc0_rdy;
  logic              r_cyc1_rdy;
  logic              r_done;

  logic [DATA_W-1:0] w_data;
  logic              w_acc;
  logic              w_take;
  logic              w_start;
  logic              w_two;
  logic [2:0]        w_type;

  assign w_data  = bus.in_data;
  assign w_acc   = bus.in_valid & r_in_ready;
  assign w_take  = w_acc & ~bus.flush;
  assign w_start = (r_state == S_IDLE) & (w_nxt == S_L0_HI);
  // Integer formats are always single-operand.
  assign w_two   = bus.ld_two & ~bus.ld_fmt[1];

  always_comb begin
    w_type = 3'd0;
    unique case (1'b1)
      (bus.ld_fmt == 2'd0): w_type = 3'd1;
      (bus.ld_fmt == 2'd1): w_type = w_two ? 3'd0 : 3'd3;
      (bus.ld_fmt == 2'd2): w_type = 3'd4;
      default:              w_type = 3'd2;
    endcase
  end

  always_comb begin
    w_nxt = r_state;
    if (r_state != S_IDLE && bus.flush) begin
      w_nxt = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:
          if (bus.ld_start && !bus.flush) w_nxt = S_L0_HI;
        S_L0_HI:
          if (w_acc) w_nxt = r_wide ? S_L0_LO : S_CYC0;
        S_L0_LO:
          if (w_acc) w_nxt = S_CYC0;
        S_CYC0:
          w_nxt = r_two ? S_L1_HI : S_IDLE;
        S_L1_HI:
          if (w_acc) w_nxt = r_wide ? S_L1_LO : S_CYC1;
        S_L1_LO:
          if (w_acc) w_nxt = S_CYC1;
        S_CYC1:
          w_nxt = S_IDLE;
        default:
          w_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_wide     <= 1'b0;
      r_two      <= 1'b0;
      r_type     <= 3'd0;
      r_op_hi    <= '0;
      r_op_lo    <= '0;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_cyc0_rdy <= 1'b0;
      r_cyc1_rdy <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_nxt;
      r_in_ready <= (w_nxt == S_L0_HI) | (w_nxt == S_L0_LO) |
                    (w_nxt == S_L1_HI) | (w_nxt == S_L1_LO);
      r_busy     <= (w_nxt != S_IDLE);
      r_cyc0_rdy <= (w_nxt == S_CYC0);
      r_cyc1_rdy <= (w_nxt == S_CYC1);
      // CYC0 is only reached from L0_*, so r_two is already latched here.
      r_done     <= ((w_nxt == S_CYC0) & ~r_two) | (w_nxt == S_CYC1);
      if (w_nxt == S_IDLE) r_type <= 3'd0;
      if (w_start) begin
        r_wide  <= bus.ld_fmt[0];
        r_two   <= w_two;
        r_type  <= w_type;
        r_op_hi <= '0;
        r_op_lo <= '0;
      end
      if (w_take) begin
        if (r_state == S_L0_HI || r_state == S_L1_HI) begin
          r_op_hi <= w_data;
          if (!r_wide) r_op_lo <= '0;
        end else begin
          r_op_lo <= w_data;
        end
      end
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.op_hi     = r_op_hi;
  assign bus.op_lo     = r_op_lo;
  assign bus.cyc0_rdy  = r_cyc0_rdy;
  assign bus.cyc1_rdy  = r_cyc1_rdy;
  assign bus.cyc0_type = r_type;
  assign bus.busy      = r_busy;
  assign bus.op_done   = r_done;

endmodule

// File: tb/tb_fp_operand_seq.sv
// Directed bench for fp_operand_seq: formats, stalls, flush, late start, reset.
// Expected values are hand-computed; each check is an immediate assertion.
module tb_fp_operand_seq;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  fp_operand_seq_if #(.DATA_W(32)) bus ();

  fp_operand_seq #(.DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input logic rdy,
                           input logic c0, input logic c1,
                           input logic dn, input logic bz);
    chk({tag, ".in_ready"}, 64'(bus.in_ready), 64'(rdy));
    chk({tag, ".cyc0_rdy"}, 64'(bus.cyc0_rdy), 64'(c0));
    chk({tag, ".cyc1_rdy"}, 64'(bus.cyc1_rdy), 64'(c1));
    chk({tag, ".op_done"}, 64'(bus.op_done), 64'(dn));
    chk({tag, ".busy"}, 64'(bus.busy), 64'(bz));
  endtask

  task automatic chk_ops(input string tag, input logic [31:0] hi,
                         input logic [31:0] lo);
    chk({tag, ".op_hi"}, 64'(bus.op_hi), 64'(hi));
    chk({tag, ".op_lo"}, 64'(bus.op_lo), 64'(lo));
  endtask

  task automatic start(input logic [1:0] fmt, input logic two);
    bus.ld_start = 1'b1;
    bus.ld_fmt   = fmt;
    bus.ld_two   = two;
    tick();
    bus.ld_start = 1'b0;
  endtask

  task automatic word(input logic [31:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    tick();
  endtask

  initial begin
    n_vec        = 0;
    n_err        = 0;
    reset        = 1'b1;
    bus.ld_start = 1'b0;
    bus.ld_fmt   = 2'd0;
    bus.ld_two   = 1'b0;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 32'h0;
    tick();
    tick();
    chk_flags("rst", 0, 0, 0, 0, 0);
    chk_ops("rst", 32'h0, 32'h0);
    chk("rst.type", 64'(bus.cyc0_type), 64'd0);
    reset = 1'b0;
    tick();

    // single, two operands
    start(2'd0, 1'b1);
    chk("s2.type", 64'(bus.cyc0_type), 64'd1);
    chk_flags("s2.l0hi", 1, 0, 0, 0, 1);
    word(32'h3F80_0000);
    chk_flags("s2.cyc0", 0, 1, 0, 0, 1);
    chk_ops("s2.cyc0", 32'h3F80_0000, 32'h0);
    word(32'h4000_0000);
    chk_flags("s2.l1hi", 1, 0, 0, 0, 1);
    chk_ops("s2.l1hi", 32'h3F80_0000, 32'h0);
    word(32'h4000_0000);
    chk_flags("s2.cyc1", 0, 0, 1, 1, 1);
    chk_ops("s2.cyc1", 32'h4000_0000, 32'h0);
    chk("s2.type1", 64'(bus.cyc0_type), 64'd1);
    bus.in_valid = 1'b0;
    tick();
    chk_flags("s2.idle", 0, 0, 0, 0, 0);
    chk_ops("s2.idle", 32'h4000_0000, 32'h0);

    // double, one operand, stall between words
    start(2'd1, 1'b0);
    chk("d1.type", 64'(bus.cyc0_type), 64'd3);
    word(32'h4009_21FB);
    chk_ops("d1.l0lo", 32'h4009_21FB, 32'h0);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_flags("d1.stall", 1, 0, 0, 0, 1);
    end
    word(32'h5444_2D18);
    chk_flags("d1.cyc0", 0, 1, 0, 1, 1);
    chk_ops("d1.cyc0", 32'h4009_21FB, 32'h5444_2D18);
    bus.in_valid = 1'b0;
    tick();
    chk_flags("d1.idle", 0, 0, 0, 0, 0);

    // double, two operands, then immediate second start
    start(2'd1, 1'b1);
    chk("d2.type", 64'(bus.cyc0_type), 64'd0);
    word(32'h3FF0_0000);
    word(32'h0000_0001);
    chk_flags("d2.cyc0", 0, 1, 0, 0, 1);
    chk_ops("d2.cyc0", 32'h3FF0_0000, 32'h0000_0001);
    word(32'h4008_0000);
    chk_ops("d2.l1hi", 32'h3FF0_0000, 32'h0000_0001);
    word(32'h4008_0000);
    chk_ops("d2.l1lo", 32'h4008_0000, 32'h0000_0001);
    word(32'h0000_0002);
    chk_flags("d2.cyc1", 0, 0, 1, 1, 1);
    chk_ops("d2.cyc1", 32'h4008_0000, 32'h0000_0002);
    bus.in_valid = 1'b0;
    bus.ld_start = 1'b1;
    bus.ld_fmt   = 2'd0;
    bus.ld_two   = 1'b0;
    tick();
    chk_flags("d2.late", 0, 0, 0, 0, 0);
    tick();
    bus.ld_start = 1'b0;
    chk_flags("d2.restart", 1, 0, 0, 0, 1);
    chk("d2.rtype", 64'(bus.cyc0_type), 64'd1);
    chk_ops("d2.rclr", 32'h0, 32'h0);
    word(32'h1234_5678);
    chk_flags("d2.r.cyc0", 0, 1, 0, 1, 1);
    chk_ops("d2.r.cyc0", 32'h1234_5678, 32'h0);
    bus.in_valid = 1'b0;
    tick();

    // flush in L1_LO with a word offered
    start(2'd1, 1'b1);
    word(32'h1111_1111);
    word(32'h2222_2222);
    word(32'h3333_3333);
    word(32'h3333_3333);
    chk_ops("fl.l1lo", 32'h3333_3333, 32'h2222_2222);
    bus.flush   = 1'b1;
    bus.in_data = 32'h4444_4444;
    chk("fl.ready", 64'(bus.in_ready), 64'd1);
    tick();
    chk_flags("fl.idle", 0, 0, 0, 0, 0);
    chk_ops("fl.hold", 32'h3333_3333, 32'h2222_2222);
    chk("fl.type", 64'(bus.cyc0_type), 64'd0);
    bus.in_valid = 1'b0;
    bus.ld_start = 1'b1;
    tick();
    chk_flags("fl.drop", 0, 0, 0, 0, 0);
    bus.ld_start = 1'b0;
    bus.flush    = 1'b0;
    tick();
    chk_flags("fl.after", 0, 0, 0, 0, 0);

    // ld_start in L0_LO is ignored
    start(2'd1, 1'b0);
    word(32'hAAAA_0000);
    bus.in_valid = 1'b0;
    bus.ld_start = 1'b1;
    bus.ld_fmt   = 2'd2;
    bus.ld_two   = 1'b1;
    tick();
    bus.ld_start = 1'b0;
    chk("ig.type", 64'(bus.cyc0_type), 64'd3);
    chk_flags("ig.l0lo", 1, 0, 0, 0, 1);
    word(32'h0000_BBBB);
    chk_flags("ig.cyc0", 0, 1, 0, 1, 1);
    chk_ops("ig.cyc0", 32'hAAAA_0000, 32'h0000_BBBB);
    bus.in_valid = 1'b0;
    tick();

    // reset in L0_LO, then long load
    start(2'd3, 1'b1);
    chk("rs.type0", 64'(bus.cyc0_type), 64'd2);
    word(32'hCAFE_0000);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_flags("rs.mid", 0, 0, 0, 0, 0);
    chk_ops("rs.mid", 32'h0, 32'h0);
    chk("rs.type", 64'(bus.cyc0_type), 64'd0);
    start(2'd3, 1'b1);
    chk("lg.type", 64'(bus.cyc0_type), 64'd2);
    word(32'h0123_4567);
    word(32'h89AB_CDEF);
    chk_flags("lg.cyc0", 0, 1, 0, 1, 1);
    chk_ops("lg.cyc0", 32'h0123_4567, 32'h89AB_CDEF);
    bus.in_valid = 1'b0;
    tick();
    chk_flags("lg.idle", 0, 0, 0, 0, 0);

    // int, two requested but treated as one
    start(2'd2, 1'b1);
    chk("in.type", 64'(bus.cyc0_type), 64'd4);
    word(32'hDEAD_BEEF);
    chk_flags("in.cyc0", 0, 1, 0, 1, 1);
    chk_ops("in.cyc0", 32'hDEAD_BEEF, 32'h0);
    bus.in_valid = 1'b0;
    tick();
    chk_flags("in.idle", 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
